hex_display_avs: RTL

//  Avalon-MM slave on the HPS lightweight bridge that drives the six DE1-SoC seven-segment

---
 rtl/hex_display_pkg.sv | 68 ++++++
 rtl/hex_display_seg.sv | 11 +
 rtl/hex_display_avs.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants, register map and segment decode for the DE1-SoC hex display slave.
package hex_display_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEG_W  = 7;

    localparam logic [ADDR_W-1:0] ADDR_VALUE = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_RAWLO = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_RAWHI = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_BLINK = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_ID    = 3'd5;

    localparam logic [DATA_W-1:0] HEX_ID = 32'h4845_5836;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_RAW    = 1;
    localparam int unsigned CTRL_LZ     = 2;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Implemented bits of each register; everything else reads as zero.
    localparam logic [DATA_W-1:0] MASK_VALUE = 32'h00FF_FFFF;
    localparam logic [DATA_W-1:0] MASK_CTRL  = 32'h0000_0007;
    localparam logic [DATA_W-1:0] MASK_RAWLO = 32'h7F7F_7F7F;
    localparam logic [DATA_W-1:0] MASK_RAWHI = 32'h0000_7F7F;
    localparam logic [DATA_W-1:0] MASK_BLINK = 32'h0000_003F;

    localparam logic [DATA_W-1:0] RST_RAWLO = 32'h7F7F_7F7F;
    localparam logic [DATA_W-1:0] RST_RAWHI = 32'h0000_7F7F;

    // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble);
        logic [SEG_W-1:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [3:0]        be);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/hex_display_seg.sv
// Combinational nibble to seven-segment decoder, one instance per digit.
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = seg_decode(nibble);

endmodule

// File: rtl/hex_display_avs.sv
// Avalon-MM slave driving six active-low seven-segment digits.
// Optional blink logic is built when HEX_BLINK_EN is defined.
module hex_display_avs
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest,
    output logic [SEG_W-1:0]  hex0,
    output logic [SEG_W-1:0]  hex1,
    output logic [SEG_W-1:0]  hex2,
    output logic [SEG_W-1:0]  hex3,
    output logic [SEG_W-1:0]  hex4,
    output logic [SEG_W-1:0]  hex5
);

    if (BLINK_DIV < 2) begin : g_div_check
        $error("BLINK_DIV must be at least 2");
    end

    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] rawlo_q;
    logic [DATA_W-1:0] rawhi_q;
    logic [DATA_W-1:0] blink_rd_c;
    logic [NUM_DIGITS-1:0] blink_bits_c;
    logic              blink_phase_c;
    logic [DATA_W-1:0] rd_mux_c;

    assign avs_waitrequest = 1'b0;

    // Writable registers with per-lane update and unimplemented bits forced to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            ctrl_q  <= '0;
            rawlo_q <= RST_RAWLO;
            rawhi_q <= RST_RAWHI;
        end else if (avs_write) begin
            case (avs_address)
                ADDR_VALUE: value_q <= byte_merge(value_q, avs_writedata, avs_byteenable) & MASK_VALUE;
                ADDR_CTRL:  ctrl_q  <= byte_merge(ctrl_q,  avs_writedata, avs_byteenable) & MASK_CTRL;
                ADDR_RAWLO: rawlo_q <= byte_merge(rawlo_q, avs_writedata, avs_byteenable) & MASK_RAWLO;
                ADDR_RAWHI: rawhi_q <= byte_merge(rawhi_q, avs_writedata, avs_byteenable) & MASK_RAWHI;
                default: ;
            endcase
        end
    end

`ifdef HEX_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0]  blink_cnt_q;
    logic              blink_phase_q;
    logic [DATA_W-1:0] blink_mask_q;
    logic              blink_clr_c;

    assign blink_clr_c = avs_write && (avs_address == ADDR_CTRL || avs_address == ADDR_BLINK);

    // Half-period counter; reconfiguring restarts it so the blink starts visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_mask_q  <= '0;
        end else begin
            if (avs_write && avs_address == ADDR_BLINK) begin
                blink_mask_q <= byte_merge(blink_mask_q, avs_writedata, avs_byteenable) & MASK_BLINK;
            end
            if (blink_clr_c) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= 1'b0;
            end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + CNT_W'(1);
            end
        end
    end

    assign blink_phase_c = blink_phase_q;
    assign blink_bits_c  = blink_mask_q[NUM_DIGITS-1:0];
    assign blink_rd_c    = blink_mask_q;
`else
    assign blink_phase_c = 1'b0;
    assign blink_bits_c  = '0;
    assign blink_rd_c    = '0;
`endif

    always_comb begin
        rd_mux_c = '0;
        case (avs_address)
            ADDR_VALUE: rd_mux_c = value_q;
            ADDR_CTRL:  rd_mux_c = ctrl_q;
            ADDR_RAWLO: rd_mux_c = rawlo_q;
            ADDR_RAWHI: rd_mux_c = rawhi_q;
            ADDR_BLINK: rd_mux_c = blink_rd_c;
            ADDR_ID:    rd_mux_c = HEX_ID;
            default:    rd_mux_c = '0;
        endcase
    end

    // Fixed one-cycle read latency; data holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_mux_c;
        end
    end

    logic [NUM_DIGITS-1:0][SEG_W-1:0] dec_seg_c;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] raw_seg_c;
    logic [NUM_DIGITS-1:0]            lz_keep_c;

    // A digit survives leading-zero blanking if it or any higher nibble is nonzero.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        hex_seg_decoder u_dec (
            .nibble (value_q[4*i +: 4]),
            .seg_c  (dec_seg_c[i])
        );
        if (i < 4) begin : g_lo
            assign raw_seg_c[i] = rawlo_q[8*i +: SEG_W];
        end else begin : g_hi
            assign raw_seg_c[i] = rawhi_q[8*(i-4) +: SEG_W];
        end
        if (i == 0) begin : g_d0
            assign lz_keep_c[i] = 1'b1;
        end else begin : g_dn
            assign lz_keep_c[i] = |value_q[4*NUM_DIGITS-1 : 4*i];
        end
    end

    logic [NUM_DIGITS-1:0][SEG_W-1:0] s1_seg_q;
    logic                             s1_en_q;
    logic [NUM_DIGITS-1:0]            s1_blank_q;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] hex_q;

    // Stage 1: segment source select plus the matching enable / blanking state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_seg_q   <= {NUM_DIGITS{SEG_OFF}};
            s1_en_q    <= 1'b0;
            s1_blank_q <= '0;
        end else begin
            s1_seg_q   <= ctrl_q[CTRL_RAW] ? raw_seg_c : dec_seg_c;
            s1_en_q    <= ctrl_q[CTRL_ENABLE];
            s1_blank_q <= (!ctrl_q[CTRL_RAW] && ctrl_q[CTRL_LZ]) ? ~lz_keep_c : '0;
        end
    end

    // Stage 2: apply masks and drive the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= (!s1_en_q || s1_blank_q[i] || (blink_phase_c && blink_bits_c[i]))
                            ? SEG_OFF : s1_seg_q[i];
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule
